// File: rtl/accumulator_memory.sv
// Operand-pool bus responder for the parallel accumulator: round-robin arbiter,
// FETCH/SEND servicing against a circular pool, and completion detection.
module accumulator_memory #(
  parameter int NPROC = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [31:0]      load_data,
  input  logic             start,
  input  logic [NPROC-1:0] req,
  input  logic [1:0]       op,
  input  logic [31:0]      write,
  output logic [NPROC-1:0] grant,
  output logic [31:0]      read,
  output logic             signal,
  output logic [AW:0]      count,
  output logic             done,
  output logic [31:0]      sum
);

  localparam int PW = (NPROC > 1) ? $clog2(NPROC) : 1;
  localparam int LW = AW + 6;

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_WAIT_OP,
    S_ACK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic [NPROC-1:0] r_grant;
  logic [31:0]      r_read;
  logic             r_signal;
  logic             r_done;
  logic [31:0]      r_sum;
  logic [PW-1:0]    r_rr;
  logic [PW-1:0]    r_gidx;
  logic [1:0]       r_held [NPROC];

  logic             w_fetch;
  logic             w_send;
  logic             w_pool_empty;
  logic             w_pool_full;
  logic             w_load_we;
  logic             w_send_we;
  logic             w_mem_we;
  logic [31:0]      w_mem_wdata;
  logic [NPROC-1:0] w_req_rot;
  logic [PW-1:0]    w_off;
  logic             w_any;
  logic [PW:0]      w_rot_sum;
  logic [PW-1:0]    w_winner;
  logic [PW-1:0]    w_rr_next;
  logic [NPROC-1:0] w_grant_next;
  logic [LW-1:0]    w_live;

  // Unknown op encodings fall through these compares as NOP.
  assign w_fetch      = (op == 2'b01);
  assign w_send       = (op == 2'b10);
  assign w_pool_empty = (r_count == '0);
  assign w_pool_full  = (r_count == (AW+1)'(DEPTH));
  assign w_load_we    = (r_state == S_LOAD) && load_en && !w_pool_full;
  assign w_send_we    = (r_state == S_WAIT_OP) && w_send;
  assign w_mem_we     = reset && (w_load_we || w_send_we);
  assign w_mem_wdata  = (r_state == S_LOAD) ? load_data : write;

  // Rotate requests so the search always starts at the round-robin pointer.
  assign w_req_rot = NPROC'({req, req} >> r_rr);

  always_comb begin
    w_any = |w_req_rot;
    w_off = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_off = PW'(i);
    end
  end

  assign w_rot_sum = {1'b0, r_rr} + {1'b0, w_off};
  assign w_winner  = (w_rot_sum >= (PW+1)'(NPROC)) ? PW'(w_rot_sum - (PW+1)'(NPROC))
                                                   : w_rot_sum[PW-1:0];
  assign w_rr_next = (w_winner == PW'(NPROC - 1)) ? '0 : w_winner + PW'(1);

  always_comb begin
    w_grant_next           = '0;
    w_grant_next[w_winner] = 1'b1;
  end

  // Words still in play: pool plus everything checked out to processors.
  always_comb begin
    w_live = LW'(r_count);
    for (int i = 0; i < NPROC; i++) begin
      w_live = w_live + LW'(r_held[i]);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:    if (start) w_state_next = w_pool_empty ? S_DONE : S_IDLE;
      S_IDLE:    if (w_any) w_state_next = S_WAIT_OP;
      S_WAIT_OP: if (w_fetch || w_send) w_state_next = S_ACK;
      S_ACK:     w_state_next = (w_live == LW'(1)) ? S_DONE : S_IDLE;
      S_DONE:    w_state_next = S_DONE;
      default:   w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_LOAD;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_tail] <= w_mem_wdata;
    r_sum <= r_mem[r_head];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_grant  <= '0;
      r_read   <= '0;
      r_signal <= 1'b0;
      r_done   <= 1'b0;
      r_rr     <= '0;
      r_gidx   <= '0;
      for (int i = 0; i < NPROC; i++) r_held[i] <= '0;
    end else begin
      r_done <= r_done || (w_state_next == S_DONE);
      case (r_state)
        S_LOAD: begin
          if (w_load_we) begin
            r_tail  <= r_tail + AW'(1);
            r_count <= r_count + (AW+1)'(1);
          end
        end
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_grant_next;
            r_gidx  <= w_winner;
            r_rr    <= w_rr_next;
          end
        end
        S_WAIT_OP: begin
          // Grant drops as signal rises so the two are never high together.
          if (w_fetch) begin
            r_signal <= 1'b1;
            r_grant  <= '0;
            if (!w_pool_empty) begin
              r_read         <= r_mem[r_head];
              r_head         <= r_head + AW'(1);
              r_count        <= r_count - (AW+1)'(1);
              r_held[r_gidx] <= r_held[r_gidx] + 2'd1;
            end else begin
              r_read <= '0;
            end
          end else if (w_send) begin
            r_signal       <= 1'b1;
            r_grant        <= '0;
            r_tail         <= r_tail + AW'(1);
            r_count        <= r_count + (AW+1)'(1);
            r_held[r_gidx] <= '0;
          end
        end
        default: begin
          r_signal <= 1'b0;
          r_grant  <= '0;
        end
      endcase
    end
  end

  assign grant  = r_grant;
  assign read   = r_read;
  assign signal = r_signal;
  assign count  = r_count;
  assign done   = r_done;
  assign sum    = r_sum;

endmodule

// File: tb/tb_accumulator_memory.sv
// Directed bench for accumulator_memory: processor models share the bus while a
// queue model of the pool supplies expected fetch data, counts and final sums.
module tb_accumulator_memory;
  localparam int NPROC = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_en;
  logic [31:0]      load_data;
  logic             start;
  logic [NPROC-1:0] req;
  logic [1:0]       op;
  logic [31:0]      write;
  logic [NPROC-1:0] grant;
  logic [31:0]      read;
  logic             signal;
  logic [AW:0]      count;
  logic             done;
  logic [31:0]      sum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pool[$];
  int          held [NPROC];
  logic [31:0] acc  [NPROC];
  int          n_empty;
  int          cyc;
  int          n_grants;
  int          grant_log [8];

  accumulator_memory #(.NPROC(NPROC), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
    .start(start), .req(req), .op(op), .write(write), .grant(grant),
    .read(read), .signal(signal), .count(count), .done(done), .sum(sum)
  );

  always #5 clk = ~clk;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task do_reset(input logic [NPROC-1:0] req_val);
    @(negedge clk);
    reset = 1'b0; load_en = 1'b0; load_data = '0; start = 1'b0;
    op = 2'b00; write = '0; req = req_val;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pool.delete();
  endtask

  task load_seq(input logic [31:0] first, input int n, input logic [31:0] step);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_data = first + step * 32'(i);
      if (pool.size() < DEPTH) pool.push_back(load_data);
    end
    @(negedge clk);
    load_en = 1'b0;
    check("load_count", 32'(count), 32'(pool.size()));
  endtask

  // Polite processors stay off the bus while a lone pooled word belongs to a holder.
  function automatic logic want(input int i, input bit greedy, input logic [NPROC-1:0] en);
    int total_held = 0;
    for (int k = 0; k < NPROC; k++) total_held += held[k];
    if (!en[i]) return 1'b0;
    if (greedy) return 1'b1;
    return (held[i] > 0) || (pool.size() >= 2) || (pool.size() >= 1 && total_held == 0);
  endfunction

  task automatic run_procs(input bit greedy, input logic [NPROC-1:0] en, input int budget);
    int          phase = 0;
    int          g = 0;
    logic [1:0]  cur_op = 2'b00;
    logic        sig_prev = 1'b0;
    logic [31:0] exp_v;
    for (int i = 0; i < NPROC; i++) begin held[i] = 0; acc[i] = '0; end
    n_empty = 0; n_grants = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < NPROC; i++) req[i] = want(i, greedy, en);
    while (cyc < budget) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      for (int i = 0; i < NPROC; i++) req[i] = want(i, greedy, en);
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (sig_prev) check("signal_width", 32'(signal), 32'd0);
      if (signal) check("grant_during_signal", 32'(grant), 32'd0);
      sig_prev = signal;
      if (done) break;
      if (signal) begin
        check("signal_expected", 32'(phase), 32'd1);
        if (cur_op == 2'b01) begin
          if (pool.size() > 0) begin
            exp_v = pool.pop_front();
            held[g]++;
            acc[g] = acc[g] + exp_v;
          end else begin
            exp_v = '0;
            n_empty++;
          end
          check("fetch_read", read, exp_v);
          $display("txn p%0d FETCH read=%0d count=%0d", g, read, count);
        end else begin
          pool.push_back(acc[g]);
          $display("txn p%0d SEND write=%0d count=%0d", g, acc[g], count);
          held[g] = 0;
          acc[g]  = '0;
        end
        check("pool_count", 32'(count), 32'(pool.size()));
        op = 2'b00; write = '0; req[g] = 1'b0; phase = 0;
      end else if (phase == 0 && grant != '0) begin
        for (int i = 0; i < NPROC; i++) if (grant[i]) g = i;
        if (n_grants < 8) grant_log[n_grants] = g;
        n_grants++;
        if (held[g] == 2 || (held[g] == 1 && pool.size() == 0)) begin
          cur_op = 2'b10; write = acc[g];
        end else begin
          cur_op = 2'b01; write = '0;
        end
        op = cur_op;
        phase = 1;
      end
    end
    check("done_within_budget", 32'(done), 32'd1);
    op = 2'b00; req = '0;
  endtask

  task automatic wait_for(input bit for_signal, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (for_signal ? signal : (grant != '0)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bit ok;

    // Reset state
    do_reset('0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_signal", 32'(signal), 32'd0);
    check("rst_read", read, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // 1: single processor, 5 + 7
    load_seq(32'd5, 2, 32'd2);
    run_procs(1'b1, 4'b0001, 200);
    check("t1_sum", sum, 32'd12);
    check("t1_count", 32'(count), 32'd1);
    check("t1_latency", 32'(cyc <= 20), 32'd1);

    // 2: four processors, 1..16
    do_reset('0);
    load_seq(32'd1, 16, 32'd1);
    run_procs(1'b0, 4'b1111, 3000);
    check("t2_sum", sum, 32'd136);
    check("t2_count", 32'(count), 32'd1);

    // 3: all requests high from reset, rotation order
    do_reset(4'b1111);
    load_seq(32'd1, 8, 32'd1);
    run_procs(1'b0, 4'b1111, 3000);
    check("t3_grant0", 32'(grant_log[0]), 32'd0);
    check("t3_grant1", 32'(grant_log[1]), 32'd1);
    check("t3_grant2", 32'(grant_log[2]), 32'd2);
    check("t3_grant3", 32'(grant_log[3]), 32'd3);
    check("t3_grant4", 32'(grant_log[4]), 32'd0);
    check("t3_sum", sum, 32'd36);

    // 4: two processors, small pool, one empty fetch
    do_reset('0);
    load_seq(32'd1, 2, 32'd1);
    run_procs(1'b1, 4'b0011, 500);
    check("t4_empty_fetches", 32'(n_empty), 32'd1);
    check("t4_sum", sum, 32'd3);

    // 6: overfill, then 5: reset during a SEND
    do_reset('0);
    load_seq(32'd100, 17, 32'd1);
    check("t6_count_full", 32'(count), 32'd16);
    req = 4'b0001;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_for(1'b0, 10, ok);
    check("t5_grant_seen", 32'(ok), 32'd1);
    check("t5_grant", 32'(grant), 32'd1);
    op = 2'b01;
    wait_for(1'b1, 10, ok);
    check("t5_fetch_seen", 32'(ok), 32'd1);
    check("t5_fetch_read", read, 32'd100);
    check("t5_fetch_count", 32'(count), 32'd15);
    $display("txn p0 FETCH read=%0d count=%0d", read, count);
    op = 2'b00; req = '0;
    @(negedge clk); req = 4'b0001;
    wait_for(1'b0, 10, ok);
    check("t5_grant2_seen", 32'(ok), 32'd1);
    reset = 1'b0; op = 2'b10; write = 32'd99;
    @(negedge clk);
    $display("txn p0 SEND write=99 aborted by reset");
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_signal", 32'(signal), 32'd0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    reset = 1'b1; op = 2'b00; write = '0; req = '0;
    pool.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t6_empty_start_done", 32'(done), 32'd1);
    check("t5_write_suppressed", sum, 32'd100);
    @(negedge clk);
    check("t6_done_sticky", 32'(done), 32'd1);
    check("t6_done_grant", 32'(grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
